// File: rtl/reg_spi_scheduler.sv
// Register-write SPI receiver with a small pending FIFO; buffered writes are
// released to the register bank only while vblank is high, in arrival order.
module reg_spi_scheduler #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_sclk,
    input  logic              reg_mosi,
    input  logic              reg_ss_n,
    input  logic              vblank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pending,
    output logic              overflow
);

    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_SHIFT    = 2'd2;

    // Sync flops reset to 0 so select reads as "low" until really sampled;
    // this keeps DISARMED from arming on a frame already in flight.
    logic [2:0] sync1_reg, sync2_reg;
    logic [1:0] sync3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= {reg_ss_n, reg_mosi, reg_sclk};
            sync2_reg <= sync1_reg;
            sync3_reg <= {sync2_reg[2], sync2_reg[0]};
        end
    end

    logic sclk_rise, ss_rise, ss_low, mosi_s;
    assign sclk_rise = sync2_reg[0] & ~sync3_reg[0];
    assign ss_rise   = sync2_reg[2] & ~sync3_reg[1];
    assign ss_low    = ~sync2_reg[2];
    assign mosi_s    = sync2_reg[1];

    logic [1:0]           state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [FRAME_LEN-1:0] sr_reg;
    logic                 frame_done;

    assign frame_done = (state_reg == ST_SHIFT) && ss_rise && (cnt_reg == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_DISARMED;
            cnt_reg   <= '0;
            sr_reg    <= '0;
        end else begin
            case (state_reg)
                ST_DISARMED: if (sync2_reg[2]) state_reg <= ST_IDLE;
                ST_IDLE: begin
                    if (ss_low) begin
                        state_reg <= ST_SHIFT;
                        cnt_reg   <= '0;
                        sr_reg    <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Select release takes priority over a coincident clock edge.
                    if (ss_rise) begin
                        state_reg <= ST_IDLE;
                    end else if (sclk_rise) begin
                        sr_reg <= {sr_reg[FRAME_LEN-2:0], mosi_s};
                        if (cnt_reg != CNT_SAT) cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_DISARMED;
            endcase
        end
    end

    logic [FRAME_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]     level_reg;
    logic                 pop, push;
    logic                 wr_en_reg, overflow_reg;
    logic [ADDR_W-1:0]    wr_addr_reg;
    logic [DATA_W-1:0]    wr_data_reg;

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign pop  = vblank && (level_reg != '0);
    assign push = frame_done && ((level_reg != LVL_FULL) || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= sr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_en_reg <= pop;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                rd_ptr_reg                 <= rd_ptr_reg + PTR_W'(1);
                {wr_addr_reg, wr_data_reg} <= mem[rd_ptr_reg];
            end
            if (push && !pop)      level_reg <= level_reg + LVL_W'(1);
            else if (pop && !push) level_reg <= level_reg - LVL_W'(1);
            if (frame_done && !push) overflow_reg <= 1'b1;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign pending  = (level_reg != '0);
    assign overflow = overflow_reg;

endmodule

// File: doc/reg_spi_scheduler.md
# reg_spi_scheduler

Receives register-write frames on the raybox-zero register SPI pins (`reg_sclk`, `reg_mosi`, `reg_ss_n`) and sequences them into the renderer's configuration registers. Commits are deferred to vertical blanking so that settings never change mid-frame. Sits between the TT wrapper's `uio_in` pins and the register bank, with the VGA timing block supplying `vblank`. A small FIFO buffers writes that arrive during the visible area.

## Interface
- `ADDR_W`, 4: register address width.
- `DATA_W`, 16: register data width. Frame length is `FRAME_LEN = ADDR_W + DATA_W` (20).
- `DEPTH`, 4: pending-write FIFO depth. Must be a power of 2, at least 2.
- `clk` in 1: system clock; everything is clocked on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reg_sclk` in 1: SPI clock. Asynchronous to `clk`; mode 0; frequency ≤ clk/4.
- `reg_mosi` in 1: SPI data. MSB first; address first, then data.
- `reg_ss_n` in 1: SPI select, active low. Asynchronous.
- `vblank` in 1: level, high during vertical blanking. Synchronous to `clk`.
- `wr_en` out 1: one-cycle commit strobe.
- `wr_addr` out ADDR_W: commit address, valid while `wr_en` is high.
- `wr_data` out DATA_W: commit data, valid while `wr_en` is high.
- `pending` out 1: FIFO not empty.
- `overflow` out 1: sticky; a valid frame was dropped because the FIFO was full.

## Operation
- Synchronisation
  - `reg_sclk`, `reg_mosi` and `reg_ss_n` each pass through 2 flops, plus a third flop for edge detection.
  - `sclk_rise` = sync2 & ~sync3.
  - `ss_rise` = sync2 & ~sync3 on the select line.
  - `ss_low` = ~sync2 on the select line.
- Receive FSM states: DISARMED, IDLE, SHIFT.
  - DISARMED is the reset state. It moves to IDLE once synchronised `reg_ss_n` is 1, so a frame already in progress at reset is ignored.
  - IDLE → SHIFT on `ss_low`. The bit counter and shift register clear on this transition.
  - SHIFT, on `sclk_rise`: shift in synchronised `reg_mosi` at the LSB and increment the counter. The counter saturates at `FRAME_LEN+1`.
  - SHIFT, on `ss_rise`: return to IDLE.
    - If the count is exactly `FRAME_LEN`, the frame is valid and is pushed as {addr = sr[FRAME_LEN-1:DATA_W], data = sr[DATA_W-1:0]}.
    - Any other count discards the frame silently.
  - If `sclk_rise` and `ss_rise` occur in the same cycle, `ss_rise` wins and the bit is not shifted.
- FIFO and commit
  - Push happens on a valid frame end. Pop happens on any edge where `vblank`=1 and the level is ≠0.
  - Push and pop in the same cycle: both happen and the level is unchanged. This includes the full case, where the push is accepted.
  - Full with no pop: the push is dropped and `overflow` is set. It stays set until reset.
  - Empty: no pop and no bypass. A frame pushed while the FIFO is empty is popped at the next edge at the earliest.
  - Writes commit strictly in arrival order, one per cycle.
  - If `vblank` falls mid-drain, draining stops immediately. The remaining entries are held for the next blanking period.
  - `wr_en`, `wr_addr` and `wr_data` are registered. On a pop they take the head entry for one cycle. Otherwise `wr_en`=0 and `wr_addr`/`wr_data` hold their last values.
- Reset values
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pending`=0, `overflow`=0.
  - FIFO empty; FSM in DISARMED.
  - Reset asserted mid-frame or mid-drain loses all buffered entries and the partial frame.

## Timing
- SPI bit latency: a raw `reg_sclk` rise sampled at edge 0 shifts its bit at edge 2.
- Frame latency: a raw `reg_ss_n` rise sampled at edge 0 pushes at edge 2, and `pending` is 1 after edge 2. With `vblank`=1, the pop is at edge 3 and `wr_en` is high for the cycle after edge 3.
- Drain rate: N queued entries with `vblank` high give N back-to-back `wr_en` cycles.
- `pending` is combinational from the FIFO level (registered state). It falls in the same cycle the last `wr_en` is high.
- SPI constraints: SCLK high and low phases ≥ 2 clk each. `reg_ss_n` high between frames ≥ 2 clk.

## Test plan
- Single write during visible area:
  - Stimulus: frame addr=0x3, data=0xA5C3 with `vblank`=0, then raise `vblank`.
  - Required: `pending`=1 while `vblank` is low; exactly one `wr_en` pulse with `wr_addr`=3, `wr_data`=0xA5C3 on the first cycle after `vblank` rises; `pending`=0 afterwards.
- Short and long frames:
  - Stimulus: a 19-bit frame, then a 21-bit frame.
  - Required: no push, `pending` stays 0, no `wr_en`, `overflow`=0.
- Overflow:
  - Stimulus: 5 valid frames (addr 1..5, data 0x1111·addr) with `vblank`=0, then `vblank`=1 for 10 cycles.
  - Required: `overflow`=1 after the 5th frame; 4 consecutive `wr_en` pulses for addr 1,2,3,4 in order.
- Interrupted drain:
  - Stimulus: 3 entries queued; `vblank` high for 2 cycles, low, then high again.
  - Required: addr 1 and 2 commit in the first window; addr 3 commits on the first cycle of the second window.
- Simultaneous push/pop at full:
  - Stimulus: FIFO holds 4 entries, `vblank`=1, and a 5th valid frame ends on the same edge as a pop.
  - Required: 5 total commits in order; `overflow`=0.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 for 1 cycle midway through a frame, with 2 entries queued; deliver the remaining bits; hold `reg_ss_n` high, then send a new valid frame (addr 0x7, data 0x0001).
  - Required: all outputs 0 immediately on reset; the partial frame is ignored; only addr 7 commits.
